// File: rtl/esp_dma_pkg.sv
// esp_dma_pkg: shared types and constants for the 64-bit ESP DMA memory responder.
package esp_dma_pkg;
  typedef enum logic [1:0] {IDLE, RD, WR} state_t;
  localparam logic [2:0] DMA_SIZE_64 = 3'b011;
  localparam int DMA_BEAT_W = 64;
  function automatic logic req_bad(input logic [2:0] size, input logic [31:0] index, input logic [31:0] length, input logic [32:0] words);
    return (size != DMA_SIZE_64) || (({1'b0, index} + {1'b0, length}) > words);
  endfunction
endpackage

// File: rtl/esp_dma_sp_ram.sv
// esp_dma_sp_ram: single-port synchronous RAM with one-cycle read latency.
module esp_dma_sp_ram
  import esp_dma_pkg::*;
#(
  parameter int WORDS = 1024,
  parameter int AW = 10
) (
  input  logic                  clk,
  input  logic                  en,
  input  logic                  we,
  input  logic [AW-1:0]         addr,
  input  logic [DMA_BEAT_W-1:0] wdata,
  output logic [DMA_BEAT_W-1:0] rdata
);
  logic [DMA_BEAT_W-1:0] mem [WORDS];
  always_ff @(posedge clk)
    if (en) begin
      if (we) mem[addr] <= wdata;
      else rdata <= mem[addr];
    end
endmodule

// File: rtl/esp_dma64_mem_responder.sv
// esp_dma64_mem_responder: memory-side responder serving ESP DMA read/write bursts from a local RAM,
// with a host port for preload and dump while idle.
module esp_dma64_mem_responder
  import esp_dma_pkg::*;
#(
  parameter int MEM_WORDS = 1024,
  parameter int ADDR_W = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  dma_read_ctrl_valid,
  output logic                  dma_read_ctrl_ready,
  input  logic [31:0]           dma_read_ctrl_data_index,
  input  logic [31:0]           dma_read_ctrl_data_length,
  input  logic [2:0]            dma_read_ctrl_data_size,
  output logic                  dma_read_chnl_valid,
  output logic [DMA_BEAT_W-1:0] dma_read_chnl_data,
  input  logic                  dma_read_chnl_ready,
  input  logic                  dma_write_ctrl_valid,
  output logic                  dma_write_ctrl_ready,
  input  logic [31:0]           dma_write_ctrl_data_index,
  input  logic [31:0]           dma_write_ctrl_data_length,
  input  logic [2:0]            dma_write_ctrl_data_size,
  input  logic                  dma_write_chnl_valid,
  input  logic [DMA_BEAT_W-1:0] dma_write_chnl_data,
  output logic                  dma_write_chnl_ready,
  input  logic                  host_en,
  input  logic                  host_we,
  input  logic [ADDR_W-1:0]     host_addr,
  input  logic [DMA_BEAT_W-1:0] host_wdata,
  output logic [DMA_BEAT_W-1:0] host_rdata,
  output logic                  busy,
  output logic                  err
);
  state_t                state;
  logic                  live;
  logic [ADDR_W-1:0]     addr;
  logic [31:0]           cnt, issued, done;
  logic                  rd_pend, wp, rp, hq;
  logic [1:0]            fcnt;
  logic [DMA_BEAT_W-1:0] fifo [2];
  logic [DMA_BEAT_W-1:0] host_hold, ram_q, ram_wdata;
  logic [ADDR_W-1:0]     ram_addr;
  logic                  rd_hs, wr_hs, pop, issue, wbeat, host_acc, ram_en, ram_we;
  assign dma_read_ctrl_ready  = live && state == IDLE;
  assign dma_write_ctrl_ready = live && state == IDLE && !dma_read_ctrl_valid;
  assign dma_read_chnl_valid  = fcnt != 2'd0;
  assign dma_read_chnl_data   = fifo[rp];
  assign dma_write_chnl_ready = state == WR && done != cnt;
  assign busy       = state != IDLE;
  assign host_rdata = hq ? ram_q : host_hold;
  assign rd_hs    = dma_read_ctrl_valid && dma_read_ctrl_ready;
  assign wr_hs    = dma_write_ctrl_valid && dma_write_ctrl_ready;
  assign pop      = dma_read_chnl_valid && dma_read_chnl_ready;
  assign wbeat    = dma_write_chnl_valid && dma_write_chnl_ready;
  // A beat consumed this cycle frees its FIFO slot, which keeps reads streaming at one per cycle.
  assign issue    = state == RD && issued < cnt && (issued - done - {31'd0, pop}) < 32'd2;
  assign host_acc = live && state == IDLE && host_en && !rd_hs && !wr_hs;
  assign ram_en    = issue || wbeat || host_acc;
  assign ram_we    = wbeat || (host_acc && host_we);
  assign ram_addr  = (issue || wbeat) ? addr : host_addr;
  assign ram_wdata = wbeat ? dma_write_chnl_data : host_wdata;
  esp_dma_sp_ram #(.WORDS(MEM_WORDS), .AW(ADDR_W)) u_ram (
    .clk(clk), .en(ram_en), .we(ram_we), .addr(ram_addr), .wdata(ram_wdata), .rdata(ram_q)
  );
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state     <= IDLE;
      live      <= 1'b0;
      addr      <= '0;
      cnt       <= '0;
      issued    <= '0;
      done      <= '0;
      rd_pend   <= 1'b0;
      wp        <= 1'b0;
      rp        <= 1'b0;
      fcnt      <= '0;
      fifo[0]   <= '0;
      fifo[1]   <= '0;
      hq        <= 1'b0;
      host_hold <= '0;
      err       <= 1'b0;
    end else begin
      live    <= 1'b1;
      rd_pend <= issue;
      if (rd_pend) fifo[wp] <= ram_q;
      wp   <= wp ^ rd_pend;
      rp   <= rp ^ pop;
      fcnt <= fcnt + {1'b0, rd_pend} - {1'b0, pop};
      hq   <= host_acc && !host_we;
      if (hq) host_hold <= ram_q;
      case (state)
        IDLE: begin
          issued <= '0;
          done   <= '0;
          if (rd_hs) begin
            state <= RD;
            addr  <= dma_read_ctrl_data_index[ADDR_W-1:0];
            cnt   <= dma_read_ctrl_data_length;
            if (req_bad(dma_read_ctrl_data_size, dma_read_ctrl_data_index, dma_read_ctrl_data_length, 33'(MEM_WORDS))) err <= 1'b1;
          end else if (wr_hs) begin
            state <= WR;
            addr  <= dma_write_ctrl_data_index[ADDR_W-1:0];
            cnt   <= dma_write_ctrl_data_length;
            if (req_bad(dma_write_ctrl_data_size, dma_write_ctrl_data_index, dma_write_ctrl_data_length, 33'(MEM_WORDS))) err <= 1'b1;
          end
        end
        RD: begin
          if (issue) begin
            addr   <= addr + 1'b1;
            issued <= issued + 32'd1;
          end
          if (pop) done <= done + 32'd1;
          if (cnt == 32'd0 || (pop && done + 32'd1 == cnt)) state <= IDLE;
        end
        WR: begin
          if (wbeat) begin
            addr <= addr + 1'b1;
            done <= done + 32'd1;
          end
          if (cnt == 32'd0 || (wbeat && done + 32'd1 == cnt)) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_esp_dma64_mem_responder.sv
// tb_esp_dma64_mem_responder: directed bench with a read-beat scoreboard and a memory model.
module tb_esp_dma64_mem_responder;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        rd_cv = 1'b0, rd_cr;
  logic [31:0] rd_idx = '0, rd_len = '0;
  logic [2:0]  rd_sz = 3'b011;
  logic        rd_v, rd_r = 1'b1;
  logic [63:0] rd_d;
  logic        wr_cv = 1'b0, wr_cr;
  logic [31:0] wr_idx = '0, wr_len = '0;
  logic [2:0]  wr_sz = 3'b011;
  logic        wr_v = 1'b0, wr_r;
  logic [63:0] wr_d = '0;
  logic        h_en = 1'b0, h_we = 1'b0;
  logic [9:0]  h_addr = '0;
  logic [63:0] h_wdata = '0, h_rdata;
  logic        busy, err;
  int checks = 0, failures = 0, beats = 0;
  logic [63:0] exp_q [$];
  logic [63:0] model [1024];
  logic        stalled = 1'b0;
  logic [63:0] held = '0;

  esp_dma64_mem_responder dut (
    .clk(clk), .rst(rst),
    .dma_read_ctrl_valid(rd_cv), .dma_read_ctrl_ready(rd_cr),
    .dma_read_ctrl_data_index(rd_idx), .dma_read_ctrl_data_length(rd_len), .dma_read_ctrl_data_size(rd_sz),
    .dma_read_chnl_valid(rd_v), .dma_read_chnl_data(rd_d), .dma_read_chnl_ready(rd_r),
    .dma_write_ctrl_valid(wr_cv), .dma_write_ctrl_ready(wr_cr),
    .dma_write_ctrl_data_index(wr_idx), .dma_write_ctrl_data_length(wr_len), .dma_write_ctrl_data_size(wr_sz),
    .dma_write_chnl_valid(wr_v), .dma_write_chnl_data(wr_d), .dma_write_chnl_ready(wr_r),
    .host_en(h_en), .host_we(h_we), .host_addr(h_addr), .host_wdata(h_wdata), .host_rdata(h_rdata),
    .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Read-channel monitor: pops the scoreboard on each beat and checks stability under backpressure.
  always @(negedge clk) begin
    if (!rst) stalled = 1'b0;
    else begin
      if (stalled) check("rd_stable", {rd_v, rd_d[62:0]}, {1'b1, held[62:0]});
      if (rd_v && rd_r) begin
        check("rd_beat", rd_d, exp_q.size() > 0 ? exp_q.pop_front() : 64'hx);
        beats++;
        stalled = 1'b0;
      end else begin
        stalled = rd_v;
        held = rd_d;
      end
    end
  end

  task automatic host_write(input logic [9:0] a, input logic [63:0] d);
    h_en = 1'b1; h_we = 1'b1; h_addr = a; h_wdata = d;
    tick();
    h_en = 1'b0; h_we = 1'b0;
    model[a] = d;
  endtask

  task automatic host_read(input logic [9:0] a, output logic [63:0] d);
    h_en = 1'b1; h_we = 1'b0; h_addr = a;
    tick();
    h_en = 1'b0;
    d = h_rdata;
  endtask

  task automatic rd_req(input logic [31:0] idx, input logic [31:0] len, input logic [2:0] sz);
    rd_cv = 1'b1; rd_idx = idx; rd_len = len; rd_sz = sz;
    #1;
    for (int k = 0; k < 100 && !rd_cr; k++) tick();
    check("rd_ctrl_ready", rd_cr, 1'b1);
    for (int i = 0; i < int'(len); i++) exp_q.push_back(model[(idx + i) % 1024]);
    tick();
    rd_cv = 1'b0;
  endtask

  task automatic wr_req(input logic [31:0] idx, input logic [31:0] len, input logic [63:0] base);
    wr_cv = 1'b1; wr_idx = idx; wr_len = len; wr_sz = 3'b011;
    #1;
    for (int k = 0; k < 100 && !wr_cr; k++) tick();
    check("wr_ctrl_ready", wr_cr, 1'b1);
    tick();
    wr_cv = 1'b0;
    for (int i = 0; i < int'(len); i++) begin
      wr_v = 1'b1; wr_d = base + 64'(i);
      #1;
      for (int k = 0; k < 100 && !wr_r; k++) tick();
      check("wr_chnl_ready", wr_r, 1'b1);
      model[(idx + i) % 1024] = wr_d;
      tick();
    end
    wr_v = 1'b0;
  endtask

  task automatic wait_idle(input bit pat);
    for (int k = 0; k < 300 && (busy || exp_q.size() > 0); k++) begin
      if (pat) rd_r = (k % 3 == 0);
      tick();
    end
    rd_r = 1'b1;
    check("idle_busy", busy, 1'b0);
    check("idle_queue", exp_q.size(), 0);
  endtask

  initial begin
    logic [63:0] d;
    int b0;
    // Reset state
    tick(); tick();
    check("rst_rd_cr", rd_cr, 1'b0);
    check("rst_wr_cr", wr_cr, 1'b0);
    check("rst_rd_v", rd_v, 1'b0);
    check("rst_wr_r", wr_r, 1'b0);
    check("rst_hrdata", h_rdata, 64'h0);
    check("rst_busy", busy, 1'b0);
    check("rst_err", err, 1'b0);
    rst = 1'b1;
    tick();
    // Preload then read with ready held high
    for (int i = 0; i < 16; i++) host_write(10'(i), 64'(i) * 64'h0101);
    host_read(10'd7, d);
    check("host_read7", d, 64'h0707);
    rd_req(32'd2, 32'd4, 3'b011);
    h_en = 1'b1; h_we = 1'b0; h_addr = 10'd3;
    check("lat_c0_valid", rd_v, 1'b0);
    tick();
    h_en = 1'b0;
    check("lat_c1_valid", rd_v, 1'b0);
    check("host_ignored_busy", h_rdata, 64'h0707);
    tick();
    check("lat_c2_valid", {rd_v, rd_d}, {1'b1, 64'h0202});
    tick();
    check("beat1", {rd_v, rd_d}, {1'b1, 64'h0303});
    tick();
    check("beat2", {rd_v, rd_d}, {1'b1, 64'h0404});
    tick();
    check("beat3", {rd_v, rd_d}, {1'b1, 64'h0505});
    tick();
    check("rd_done_idle", busy, 1'b0);
    check("rd_err", err, 1'b0);
    // Backpressure
    b0 = beats;
    rd_req(32'd2, 32'd4, 3'b011);
    wait_idle(1'b1);
    check("bp_beats", beats - b0, 4);
    // Write with wrap, then dump
    wr_req(32'd1020, 32'd8, 64'hA0);
    wait_idle(1'b0);
    check("wr_err", err, 1'b1);
    wr_v = 1'b1;
    #1;
    check("wr_idle_not_ready", wr_r, 1'b0);
    wr_v = 1'b0;
    for (int i = 0; i < 4; i++) begin
      host_read(10'(1020 + i), d);
      check("dump_hi", d, 64'hA0 + 64'(i));
      host_read(10'(i), d);
      check("dump_lo", d, 64'hA4 + 64'(i));
    end
    // Arbitration with zero-length read
    b0 = beats;
    rd_cv = 1'b1; rd_idx = 32'd0; rd_len = 32'd0; rd_sz = 3'b011;
    wr_cv = 1'b1; wr_idx = 32'd8; wr_len = 32'd2;
    #1;
    check("arb_rd_cr", rd_cr, 1'b1);
    check("arb_wr_cr", wr_cr, 1'b0);
    tick();
    rd_cv = 1'b0;
    check("arb_busy", {busy, wr_cr}, 2'b10);
    tick();
    check("arb_idle", {busy, wr_cr, rd_v}, 3'b010);
    wr_req(32'd8, 32'd2, 64'hB0);
    wait_idle(1'b0);
    check("arb_no_rd_beats", beats - b0, 0);
    host_read(10'd8, d);
    check("arb_mem8", d, 64'hB0);
    host_read(10'd9, d);
    check("arb_mem9", d, 64'hB1);
    // Bad size
    rst = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    check("reset_clears_err", err, 1'b0);
    b0 = beats;
    rd_req(32'd0, 32'd2, 3'b010);
    wait_idle(1'b0);
    check("bad_size_beats", beats - b0, 2);
    check("bad_size_err", err, 1'b1);
    repeat (5) tick();
    check("bad_size_err_held", err, 1'b1);
    // Reset mid-burst
    b0 = beats;
    rd_req(32'd0, 32'd16, 3'b011);
    for (int k = 0; k < 100 && beats < b0 + 2; k++) tick();
    check("midburst_beats", beats - b0, 2);
    rst = 1'b0;
    #1;
    exp_q.delete();
    check("mid_rst_outs", {rd_v, rd_cr, wr_cr, wr_r, busy, err}, 6'b0);
    tick(); tick();
    rst = 1'b1;
    tick();
    b0 = beats;
    rd_req(32'd4, 32'd3, 3'b011);
    wait_idle(1'b0);
    check("fresh_beats", beats - b0, 3);
    check("fresh_err", err, 1'b0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end
endmodule
